// File: rtl/axis_gesture_detector.sv
// Per-axis tilt gesture detector: qualifies sustained over-threshold samples into one-shot
// POS/NEG events, presented through a single-entry valid/ready output register.
module axis_gesture_detector #(
    parameter logic signed [15:0] THRESH       = 16'sd2000,
    parameter int                 HOLD_SAMPLES = 4,
    parameter int                 COOL_SAMPLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] angle,
    input  logic        axis_motion,
    output logic        gest_valid,
    input  logic        gest_ready,
    output logic [1:0]  gest_code,
    output logic        drop,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        POS_PEND = 2'b01,
        NEG_PEND = 2'b10,
        COOLDOWN = 2'b11
    } state_t;

    localparam logic [7:0] HOLD = 8'(HOLD_SAMPLES);
    localparam logic [7:0] COOL = 8'(COOL_SAMPLES);
    localparam logic signed [16:0] TH17   = {THRESH[15], THRESH};
    localparam logic signed [16:0] NTH17  = -TH17;
    localparam logic signed [16:0] HALF17 = TH17 >>> 1;
    localparam logic [1:0] CODE_POS = 2'b01;
    localparam logic [1:0] CODE_NEG = 2'b10;

    state_t      cur, nxt;
    logic [7:0]  cnt, cnt_n, cnt_inc;
    logic        fire;
    logic [1:0]  fire_code;

    // 17-bit signed view so that -32768 negates cleanly.
    logic signed [16:0] a17, abs17;
    logic               over_pos, over_neg, calm;

    assign a17      = {angle[15], angle};
    assign abs17    = a17[16] ? -a17 : a17;
    assign over_pos = a17 > TH17;
    assign over_neg = a17 < NTH17;
    assign calm     = abs17 <= HALF17;
    assign cnt_inc  = cnt + 8'd1;
    assign state    = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= IDLE;
            cnt <= 8'd0;
        end else begin
            cur <= nxt;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        nxt       = cur;
        cnt_n     = cnt;
        fire      = 1'b0;
        fire_code = 2'b00;
        if (in_valid) begin
            case (cur)
                IDLE: begin
                    if (axis_motion && (over_pos || over_neg)) begin
                        if (HOLD_SAMPLES == 1) begin
                            fire      = 1'b1;
                            fire_code = over_pos ? CODE_POS : CODE_NEG;
                            nxt       = COOLDOWN;
                            cnt_n     = 8'd0;
                        end else begin
                            nxt   = over_pos ? POS_PEND : NEG_PEND;
                            cnt_n = 8'd1;
                        end
                    end
                end
                POS_PEND, NEG_PEND: begin
                    if ((cur == POS_PEND) ? over_pos : over_neg) begin
                        if (cnt_inc == HOLD) begin
                            fire      = 1'b1;
                            fire_code = (cur == POS_PEND) ? CODE_POS : CODE_NEG;
                            nxt       = COOLDOWN;
                            cnt_n     = 8'd0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        nxt   = IDLE;
                        cnt_n = 8'd0;
                    end
                end
                default: begin
                    // cnt holds samples already spent here, saturating at COOL.
                    if (calm && cnt >= COOL) begin
                        nxt   = IDLE;
                        cnt_n = 8'd0;
                    end else begin
                        cnt_n = (cnt >= COOL) ? COOL : cnt_inc;
                    end
                end
            endcase
        end
    end

    // Single-entry output register; the FSM never waits on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            gest_valid <= 1'b0;
            gest_code  <= 2'b00;
            drop       <= 1'b0;
        end else if (fire) begin
            if (!gest_valid || gest_ready) begin
                gest_valid <= 1'b1;
                gest_code  <= fire_code;
            end else begin
                drop <= 1'b1;
            end
        end else if (gest_valid && gest_ready) begin
            gest_valid <= 1'b0;
            gest_code  <= 2'b00;
        end
    end

endmodule

// File: tb/tb_axis_gesture_detector.sv
// Bench for axis_gesture_detector: directed scenarios plus randomized traffic against a
// sample-level behavioural model of the gesture rules.
module tb_axis_gesture_detector;

    localparam int TH   = 2000;
    localparam int HOLD = 4;
    localparam int COOL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] angle = 16'd0;
    logic        axis_motion = 1'b0;
    logic        gest_ready = 1'b0;
    logic        gest_valid;
    logic [1:0]  gest_code;
    logic        drop;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    // model: phase 0 idle, 1 waiting on positive run, 2 negative run, 3 cooling
    int   m_phase, m_run, m_cool;
    logic m_valid, m_drop;
    logic [1:0] m_code;

    always #5 clk = ~clk;

    axis_gesture_detector #(.THRESH(16'sd2000), .HOLD_SAMPLES(HOLD), .COOL_SAMPLES(COOL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .angle(angle), .axis_motion(axis_motion),
        .gest_valid(gest_valid), .gest_ready(gest_ready), .gest_code(gest_code),
        .drop(drop), .state(state)
    );

    function automatic logic [1:0] model_sample(input int a, input logic mot);
        logic [1:0] ev;
        ev = 2'b00;
        if (m_phase == 3) begin
            if ((a < 0 ? -a : a) <= TH / 2 && m_cool >= COOL) m_phase = 0;
            else if (m_cool < COOL) m_cool++;
        end else if (m_phase == 0) begin
            if (mot && (a > TH || a < -TH)) begin
                m_phase = (a > TH) ? 1 : 2;
                m_run   = 1;
            end
        end else if ((m_phase == 1 && a > TH) || (m_phase == 2 && a < -TH)) begin
            m_run++;
        end else begin
            m_phase = 0;
        end
        if ((m_phase == 1 || m_phase == 2) && m_run >= HOLD) begin
            ev      = (m_phase == 1) ? 2'b01 : 2'b10;
            m_phase = 3;
            m_cool  = 0;
        end
        return ev;
    endfunction

    task automatic step(input logic iv, input int a, input logic mot, input logic rdy);
        logic [1:0] ev;
        in_valid    = iv;
        angle       = 16'(a);
        axis_motion = mot;
        gest_ready  = rdy;
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_run = 0; m_cool = 0;
            m_valid = 0; m_code = 0; m_drop = 0;
        end else begin
            ev = iv ? model_sample(a, mot) : 2'b00;
            if (ev != 2'b00) begin
                if (!m_valid || rdy) begin m_valid = 1; m_code = ev; end
                else m_drop = 1;
            end else if (m_valid && rdy) begin
                m_valid = 0; m_code = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step(0, 0, 0, 0);
        total++;
        if ({gest_valid, gest_code, drop, state} !== 6'b0) begin
            bad++;
            $display("FAIL reset: valid=%b code=%b drop=%b state=%b want all zero",
                     gest_valid, gest_code, drop, state);
        end
    endtask

    task automatic test_pos_basic();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 2500, i == 0, 1);
        total++;
        if (gest_valid !== 1'b0 || state !== 2'b01) begin
            bad++; $display("FAIL pos_pending: valid=%b state=%b want 0/01", gest_valid, state);
        end
        step(1, 2500, 0, 1);
        total++;
        if (gest_valid !== 1'b1 || gest_code !== 2'b01 || state !== 2'b11) begin
            bad++;
            $display("FAIL pos_fire: valid=%b code=%b state=%b want 1/01/11", gest_valid, gest_code, state);
        end
        step(0, 0, 0, 1);
        total++;
        if (gest_valid !== 1'b0 || gest_code !== 2'b00) begin
            bad++; $display("FAIL pos_pulse: valid=%b code=%b want 0/00", gest_valid, gest_code);
        end
    endtask

    task automatic test_neg_hold();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, -2001, i == 0, 1);
        step(1, -1999, 0, 1);
        total++;
        if (gest_valid !== 1'b0 || state !== 2'b00) begin
            bad++; $display("FAIL neg_abort: valid=%b state=%b want 0/00", gest_valid, state);
        end
        for (int i = 0; i < 4; i++) step(1, -2001, i == 0, 1);
        total++;
        if (gest_valid !== 1'b1 || gest_code !== 2'b10) begin
            bad++; $display("FAIL neg_fire: valid=%b code=%b want 1/10", gest_valid, gest_code);
        end
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2500, i == 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        total++;
        if (state !== 2'b00) begin
            bad++; $display("FAIL cool_exit: state=%b want 00", state);
        end
        for (int i = 0; i < 4; i++) step(1, -2500, i == 0, 0);
        total++;
        if (gest_valid !== 1'b1 || gest_code !== 2'b01 || drop !== 1'b1) begin
            bad++;
            $display("FAIL drop_kept: valid=%b code=%b drop=%b want 1/01/1", gest_valid, gest_code, drop);
        end
        step(0, 0, 0, 1);
        total++;
        if (gest_valid !== 1'b0 || drop !== 1'b1) begin
            bad++; $display("FAIL drop_accept: valid=%b drop=%b want 0/1", gest_valid, drop);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2500, i == 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, -2500, i == 0, 0);
        step(1, -2500, 0, 1);
        total++;
        if (gest_valid !== 1'b1 || gest_code !== 2'b10 || drop !== 1'b0) begin
            bad++;
            $display("FAIL b2b: valid=%b code=%b drop=%b want 1/10/0", gest_valid, gest_code, drop);
        end
    endtask

    task automatic test_min_and_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step(1, -32768, i == 0, 1);
        total++;
        if (gest_valid !== 1'b1 || gest_code !== 2'b10) begin
            bad++; $display("FAIL min_angle: valid=%b code=%b want 1/10", gest_valid, gest_code);
        end
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 2500, i == 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 2500, 0, 1);
        total++;
        if (gest_valid !== 1'b0 || state !== 2'b00) begin
            bad++; $display("FAIL mid_reset: valid=%b state=%b want 0/00", gest_valid, state);
        end
    endtask

    task automatic test_random();
        int pool[12] = '{0, 1000, -1000, 1001, -1001, 2000, -2000, 2001, -2001, 32767, -32768, 2500};
        int a;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(3) == 0) ? (int'($urandom_range(65535)) - 32768)
                                         : pool[$urandom_range(11)];
            step($urandom_range(3) != 0, a, $urandom_range(1), $urandom_range(3) == 0);
            total++;
            if (gest_valid !== m_valid || gest_code !== m_code || drop !== m_drop ||
                state !== 2'(m_phase)) begin
                bad++;
                $display("FAIL random[%0d]: got v=%b c=%b d=%b s=%b want v=%b c=%b d=%b s=%0d",
                         n, gest_valid, gest_code, drop, state, m_valid, m_code, m_drop, m_phase);
            end
        end
    endtask

    initial begin
        m_phase = 0; m_run = 0; m_cool = 0;
        m_valid = 0; m_code = 0; m_drop = 0;
        #1;
        test_reset();
        test_pos_basic();
        test_neg_hold();
        test_drop();
        test_back_to_back();
        test_min_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
